ahf_dm_writeback_v: RTL and testbench

- Write-back engine for the data-side cache of the mRISC521 memory subsystem.
- Counterpart of the instruction-cache fill path: it moves data from cache to memory, where the fill path moves it from memory to cache.
- On an eviction request it reads one 16-word block out of the cache RAM and writes it to the 1K-word DM RAM, then acknowledges.
- The data-cache controller holds its stall while busy is high.

---
 rtl/ahf_dm_writeback_v.sv | 159 +++++++++++++++
 tb/tb_ahf_dm_writeback_v.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahf_dm_writeback_v.sv
// ahf_dm_writeback_v: data-cache write-back engine; copies one 16-word cache block into DM RAM.
// Optional AHF_WB_SKIPCLEAN_EN: only words flagged in word_dirty are written, timing unchanged.
module ahf_dm_writeback_v #(
    parameter int WORD_W   = 14,
    parameter int BLK_BITS = 3,
    parameter int TAG_W    = 6
) (
    input  logic                  Clk0,
    input  logic                  Resetn,
    input  logic                  evict_req,
    input  logic [BLK_BITS-1:0]   evict_blk,
    input  logic [TAG_W-1:0]      evict_tag,
    input  logic [15:0]           word_dirty,
    output logic [BLK_BITS+3:0]   cache_addr,
    output logic                  cache_rd,
    input  logic [WORD_W-1:0]     cache_data,
    output logic [TAG_W+3:0]      dm_addr,
    output logic [WORD_W-1:0]     dm_data,
    output logic                  dm_wren,
    output logic                  busy,
    output logic                  evict_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [4:0]            rd_cnt_reg, rd_cnt_next;
    logic [4:0]            wr_cnt_reg, wr_cnt_next;
    logic [BLK_BITS-1:0]   blk_reg, blk_next;
    logic [TAG_W-1:0]      tag_reg, tag_next;
    logic [15:0]           dirty_reg, dirty_next;
    logic                  data_valid_reg, data_valid_next;
    logic [BLK_BITS+3:0]   cache_addr_reg, cache_addr_next;
    logic                  cache_rd_reg, cache_rd_next;
    logic [TAG_W+3:0]      dm_addr_reg, dm_addr_next;
    logic [WORD_W-1:0]     dm_data_reg, dm_data_next;
    logic                  dm_wren_reg, dm_wren_next;
    logic                  busy_reg, busy_next;
    logic                  evict_ack_reg, evict_ack_next;
    logic                  slot_wren;

`ifdef AHF_WB_SKIPCLEAN_EN
    assign slot_wren = dirty_reg[wr_cnt_reg[3:0]];
`else
    logic unused_dirty;
    assign slot_wren    = 1'b1;
    assign unused_dirty = ^{dirty_reg, word_dirty};
`endif

    always_comb begin
        state_next      = state_reg;
        rd_cnt_next     = rd_cnt_reg;
        wr_cnt_next     = wr_cnt_reg;
        blk_next        = blk_reg;
        tag_next        = tag_reg;
        dirty_next      = dirty_reg;
        data_valid_next = cache_rd_reg;
        cache_addr_next = cache_addr_reg;
        cache_rd_next   = 1'b0;
        dm_addr_next    = dm_addr_reg;
        dm_data_next    = dm_data_reg;
        dm_wren_next    = 1'b0;
        busy_next       = busy_reg;
        evict_ack_next  = 1'b0;

        // cache_data now holds the word whose read strobe was registered one edge ago
        if (data_valid_reg) begin
            dm_addr_next = {tag_reg, wr_cnt_reg[3:0]};
            dm_data_next = cache_data;
            dm_wren_next = slot_wren;
            wr_cnt_next  = wr_cnt_reg + 5'd1;
        end

        case (state_reg)
            IDLE: begin
                if (evict_req) begin
                    blk_next        = evict_blk;
                    tag_next        = evict_tag;
                    dirty_next      = word_dirty;
                    busy_next       = 1'b1;
                    cache_addr_next = {evict_blk, 4'd0};
                    cache_rd_next   = 1'b1;
                    rd_cnt_next     = 5'd1;
                    wr_cnt_next     = 5'd0;
                    state_next      = READ;
                end
            end
            READ: begin
                cache_addr_next = {blk_reg, rd_cnt_reg[3:0]};
                cache_rd_next   = 1'b1;
                rd_cnt_next     = rd_cnt_reg + 5'd1;
                if (rd_cnt_reg == 5'd15) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (data_valid_reg && wr_cnt_reg == 5'd15) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                busy_next      = 1'b0;
                evict_ack_next = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk0) begin
        if (!Resetn) begin
            state_reg      <= IDLE;
            rd_cnt_reg     <= 5'd0;
            wr_cnt_reg     <= 5'd0;
            blk_reg        <= '0;
            tag_reg        <= '0;
            dirty_reg      <= '0;
            data_valid_reg <= 1'b0;
            cache_addr_reg <= '0;
            cache_rd_reg   <= 1'b0;
            dm_addr_reg    <= '0;
            dm_data_reg    <= '0;
            dm_wren_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            evict_ack_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rd_cnt_reg     <= rd_cnt_next;
            wr_cnt_reg     <= wr_cnt_next;
            blk_reg        <= blk_next;
            tag_reg        <= tag_next;
            dirty_reg      <= dirty_next;
            data_valid_reg <= data_valid_next;
            cache_addr_reg <= cache_addr_next;
            cache_rd_reg   <= cache_rd_next;
            dm_addr_reg    <= dm_addr_next;
            dm_data_reg    <= dm_data_next;
            dm_wren_reg    <= dm_wren_next;
            busy_reg       <= busy_next;
            evict_ack_reg  <= evict_ack_next;
        end
    end

    assign cache_addr = cache_addr_reg;
    assign cache_rd   = cache_rd_reg;
    assign dm_addr    = dm_addr_reg;
    assign dm_data    = dm_data_reg;
    assign dm_wren    = dm_wren_reg;
    assign busy       = busy_reg;
    assign evict_ack  = evict_ack_reg;

endmodule

// File: tb/tb_ahf_dm_writeback_v.sv
// Testbench for ahf_dm_writeback_v: per-cycle output trace checked against a timing-rule model.
module tb_ahf_dm_writeback_v;

    localparam int DEPTH = 8192;
`ifdef AHF_WB_SKIPCLEAN_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        Clk0 = 1'b0;
    logic        Resetn = 1'b0;
    logic        evict_req = 1'b0;
    logic [2:0]  evict_blk = 3'd0;
    logic [5:0]  evict_tag = 6'd0;
    logic [15:0] word_dirty = 16'hFFFF;
    logic [6:0]  cache_addr;
    logic        cache_rd;
    logic [13:0] cache_data;
    logic [9:0]  dm_addr;
    logic [13:0] dm_data;
    logic        dm_wren;
    logic        busy;
    logic        evict_ack;

    logic [13:0] mem [0:127];
    // trace layout: busy[34] cache_rd[33] cache_addr[32:26] ack[25] wren[24] dm_addr[23:14] dm_data[13:0]
    logic [34:0] obs_tr [0:DEPTH-1];
    bit   [34:0] exp_tr [0:DEPTH-1];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    ahf_dm_writeback_v dut (
        .Clk0       (Clk0),
        .Resetn     (Resetn),
        .evict_req  (evict_req),
        .evict_blk  (evict_blk),
        .evict_tag  (evict_tag),
        .word_dirty (word_dirty),
        .cache_addr (cache_addr),
        .cache_rd   (cache_rd),
        .cache_data (cache_data),
        .dm_addr    (dm_addr),
        .dm_data    (dm_data),
        .dm_wren    (dm_wren),
        .busy       (busy),
        .evict_ack  (evict_ack)
    );

    always #5 Clk0 = ~Clk0;

    always @(posedge Clk0) cyc <= cyc + 1;

    // cache RAM with registered read
    always @(posedge Clk0) begin
        if (cache_rd) cache_data <= mem[cache_addr];
    end

    always @(negedge Clk0) begin
        if (cyc < DEPTH)
            obs_tr[cyc] <= {busy, cache_rd, (cache_rd ? cache_addr : 7'd0), evict_ack, dm_wren,
                            (dm_wren ? dm_addr : 10'd0), (dm_wren ? dm_data : 14'd0)};
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: a request accepted at negedge-cycle c0 keeps busy for 18 cycles, reads word k at
    // c0+k, writes word k at c0+2+k, acks at c0+18. Effects at or after 'cut' are lost to a reset.
    function automatic void add_txn(int c0, int cut, logic [2:0] blk, logic [5:0] tag, logic [15:0] dirty);
        logic [6:0] ra;
        for (int k = 0; k < 18; k++)
            if (c0 + k < cut) exp_tr[c0 + k][34] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ra = {blk, k[3:0]};
            if (c0 + k < cut) begin
                exp_tr[c0 + k][33]    = 1'b1;
                exp_tr[c0 + k][32:26] = ra;
            end
            if ((c0 + 2 + k < cut) && (!SKIP || dirty[k])) begin
                exp_tr[c0 + 2 + k][24]    = 1'b1;
                exp_tr[c0 + 2 + k][23:14] = {tag, k[3:0]};
                exp_tr[c0 + 2 + k][13:0]  = mem[ra];
            end
        end
        if (c0 + 18 < cut) exp_tr[c0 + 18][25] = 1'b1;
    endfunction

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 128; i++)
            mem[i] = rnd ? 14'($urandom) : 14'(14'h1000 + i);
    endtask

    task automatic wait_neg(input int c);
        while (cyc < c) @(negedge Clk0);
    endtask

    task automatic rand_inputs();
        evict_blk  = 3'($urandom_range(0, 7));
        evict_tag  = 6'($urandom_range(0, 63));
        word_dirty = 16'($urandom);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        evict_req = 1'b1;
        evict_blk = 3'd5;
        evict_tag = 6'h11;
        repeat (3) @(negedge Clk0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (evict_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", evict_ack); end
        checks++; if (dm_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", dm_wren); end
        checks++; if (cache_rd !== 1'b0) begin errors++; $display("FAIL reset_cache_rd got=%b exp=0", cache_rd); end
        checks++; if (cache_addr !== 7'd0) begin errors++; $display("FAIL reset_cache_addr got=%h exp=0", cache_addr); end
        checks++; if (dm_addr !== 10'd0) begin errors++; $display("FAIL reset_dm_addr got=%h exp=0", dm_addr); end
        checks++; if (dm_data !== 14'd0) begin errors++; $display("FAIL reset_dm_data got=%h exp=0", dm_data); end
        evict_req = 1'b0;
        Resetn = 1'b1;
        repeat (2) @(negedge Clk0);
        for (int c = 1; c < cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                errors++; $display("FAIL reset_trace cyc=%0d got=%h exp=%h", c, obs_tr[c], exp_tr[c]);
            end
        end
    endtask

    task automatic test_idle_quiet();
        int t0;
        t0 = cyc;
        evict_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rand_inputs();
            @(negedge Clk0);
        end
        for (int c = t0; c < cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                errors++; $display("FAIL idle_quiet cyc=%0d got=%h exp=%h", c, obs_tr[c], exp_tr[c]);
            end
        end
    endtask

    task automatic test_basic();
        int t0, c0, nwr;
        fill_mem(1'b0);
        t0 = cyc;
        c0 = t0 + 1;
        evict_blk = 3'd3; evict_tag = 6'h2A; word_dirty = 16'hFFFF; evict_req = 1'b1;
        add_txn(c0, DEPTH, 3'd3, 6'h2A, 16'hFFFF);
        wait_neg(c0 + 18); evict_req = 1'b0;
        wait_neg(c0 + 25);
        nwr = 0;
        for (int c = t0; c < cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                errors++; $display("FAIL basic cyc=+%0d got=%h exp=%h", c - c0, obs_tr[c], exp_tr[c]);
            end
            if (obs_tr[c][24] === 1'b1) nwr++;
        end
        checks++;
        if (nwr != 16) begin errors++; $display("FAIL basic_write_count got=%0d exp=16", nwr); end
    endtask

    task automatic test_back_to_back();
        int t0, c0, c1, nwr;
        fill_mem(1'b0);
        t0 = cyc;
        c0 = t0 + 1;
        c1 = c0 + 19;
        evict_blk = 3'd0; evict_tag = 6'h00; word_dirty = 16'hFFFF; evict_req = 1'b1;
        add_txn(c0, DEPTH, 3'd0, 6'h00, 16'hFFFF);
        add_txn(c1, DEPTH, 3'd7, 6'h3F, 16'hFFFF);
        wait_neg(c0 + 18); evict_blk = 3'd7; evict_tag = 6'h3F;
        wait_neg(c1 + 18); evict_req = 1'b0;
        wait_neg(c1 + 25);
        nwr = 0;
        for (int c = t0; c < cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                errors++; $display("FAIL back_to_back cyc=+%0d got=%h exp=%h", c - c0, obs_tr[c], exp_tr[c]);
            end
            if (obs_tr[c][24] === 1'b1) nwr++;
        end
        checks++;
        if (nwr != (SKIP ? 32 : 32)) begin errors++; $display("FAIL back_to_back_write_count got=%0d exp=32", nwr); end
    endtask

    task automatic test_input_change();
        int t0, c0;
        fill_mem(1'b1);
        t0 = cyc;
        c0 = t0 + 1;
        rand_inputs();
        evict_req = 1'b1;
        add_txn(c0, DEPTH, evict_blk, evict_tag, word_dirty);
        wait_neg(c0 + 3);  rand_inputs();
        wait_neg(c0 + 10); rand_inputs();
        wait_neg(c0 + 17); rand_inputs();
        wait_neg(c0 + 18); evict_req = 1'b0;
        wait_neg(c0 + 25);
        for (int c = t0; c < cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                errors++; $display("FAIL input_change cyc=+%0d got=%h exp=%h", c - c0, obs_tr[c], exp_tr[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0, c0, c1, nack;
        fill_mem(1'b0);
        t0 = cyc;
        c0 = t0 + 1;
        evict_blk = 3'd3; evict_tag = 6'h2A; word_dirty = 16'hFFFF; evict_req = 1'b1;
        add_txn(c0, c0 + 7, 3'd3, 6'h2A, 16'hFFFF);
        wait_neg(c0 + 6); Resetn = 1'b0; evict_req = 1'b0;
        wait_neg(c0 + 8); Resetn = 1'b1;
        wait_neg(c0 + 10); evict_req = 1'b1;
        c1 = c0 + 11;
        add_txn(c1, DEPTH, 3'd3, 6'h2A, 16'hFFFF);
        wait_neg(c1 + 18); evict_req = 1'b0;
        wait_neg(c1 + 25);
        nack = 0;
        for (int c = t0; c < cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                errors++; $display("FAIL reset_mid cyc=+%0d got=%h exp=%h", c - c0, obs_tr[c], exp_tr[c]);
            end
            if (obs_tr[c][25] === 1'b1) nack++;
        end
        checks++;
        if (nack != 1) begin errors++; $display("FAIL reset_mid_ack_count got=%0d exp=1", nack); end
    endtask

    task automatic test_skipclean();
        int t0, c0, nwr, exp_wr;
        fill_mem(1'b1);
        t0 = cyc;
        c0 = t0 + 1;
        evict_blk = 3'($urandom_range(0, 7));
        evict_tag = 6'($urandom_range(0, 63));
        word_dirty = 16'h8001;
        evict_req = 1'b1;
        add_txn(c0, DEPTH, evict_blk, evict_tag, 16'h8001);
        wait_neg(c0 + 18); evict_req = 1'b0;
        wait_neg(c0 + 25);
        nwr = 0;
        for (int c = t0; c < cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                errors++; $display("FAIL skipclean cyc=+%0d got=%h exp=%h", c - c0, obs_tr[c], exp_tr[c]);
            end
            if (obs_tr[c][24] === 1'b1) nwr++;
        end
        exp_wr = SKIP ? 2 : 16;
        checks++;
        if (nwr != exp_wr) begin errors++; $display("FAIL skipclean_write_count got=%0d exp=%0d", nwr, exp_wr); end
    endtask

    task automatic test_random();
        int t0, c0, gap;
        fill_mem(1'b1);
        t0 = cyc;
        c0 = t0 + 1;
        rand_inputs();
        evict_req = 1'b1;
        for (int n = 0; n < 12; n++) begin
            add_txn(c0, DEPTH, evict_blk, evict_tag, word_dirty);
            gap = $urandom_range(0, 3);
            wait_neg(c0 + 6); rand_inputs();
            wait_neg(c0 + 18);
            if (n == 11) begin
                evict_req = 1'b0;
            end else if (gap == 0) begin
                rand_inputs();
            end else begin
                evict_req = 1'b0;
                wait_neg(c0 + 18 + gap);
                rand_inputs();
                evict_req = 1'b1;
            end
            if (n != 11) c0 = c0 + 19 + gap;
        end
        wait_neg(c0 + 25);
        for (int c = t0; c < cyc; c++) begin
            checks++;
            if (obs_tr[c] !== exp_tr[c]) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_tr[c], exp_tr[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_quiet();
        test_basic();
        test_back_to_back();
        test_input_change();
        test_reset_mid();
        test_skipclean();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
